// File: rtl/line_memory_if.sv
// line_memory_if: cache-side request/response bundle for the line memory.
//   master (cache controller): drives addr_i, data_i, enable_i, write_i; receives ack_o, data_o
//   slave  (line_memory)     : receives the request; drives ack_o and data_o
interface line_memory_if #(parameter int LINE_W = 256);
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  modport master (output addr_i, data_i, enable_i, write_i, input ack_o, data_o);
  modport slave (input addr_i, data_i, enable_i, write_i, output ack_o, data_o);
endinterface

// File: rtl/line_memory.sv
// line_memory: fixed-latency 256-bit line read/write memory behind the data cache.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-low reset (storage contents are kept)
//   bus   : line_memory_if.slave -- addr_i/data_i/enable_i/write_i request, ack_o/data_o response
module line_memory #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input logic          clk_i,
  input logic          rst_i,
  line_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t            state, next;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     idx;
  logic              wr;
  logic [LINE_W-1:0] wdata, rdata;
  logic [LINE_W-1:0] mem [DEPTH];
  logic              done;
  logic              unused;
  // Only the line index bits matter; offset and upper bits wrap away.
  assign unused = ^{bus.addr_i[31:AW+5], bus.addr_i[4:0]};
  // WAIT is always visited, so ACK lands on edge LATENCY even for LATENCY=1.
  assign done = state == WAIT && cnt == CW'(LATENCY - 1);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wr    <= 1'b0;
      wdata <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.enable_i) begin
        cnt   <= '0;
        idx   <= bus.addr_i[AW+4:5];
        wr    <= bus.write_i;
        wdata <= bus.data_i;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  // Storage has no reset; reset forces IDLE, so an interrupted request never reaches it.
  always_ff @(posedge clk_i) begin
    if (done) begin
      if (wr) mem[idx] <= wdata;
      else rdata <= mem[idx];
    end
  end
  always_comb begin
    next = state == IDLE ? (bus.enable_i ? WAIT : IDLE) :
           state == WAIT ? (done ? ACK : WAIT) : IDLE;
  end
  always_comb begin
    bus.ack_o  = state == ACK;
    bus.data_o = (state == ACK && !wr) ? rdata : '0;
  end
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: scoreboard bench for line_memory at LATENCY=10 and LATENCY=1.
module tb_line_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, rst1;
  line_memory_if b0 ();
  line_memory_if b1 ();
  line_memory dut0 (.clk_i(clk), .rst_i(rst0), .bus(b0));
  line_memory #(.LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(b1));
  typedef struct {
    int         cyc;
    logic [255:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit just_acked[2];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (b0.ack_o) begin
      if (q0.size() == 0) check("dut0 spurious ack", 256'(b0.ack_o), 0);
      else begin
        e = q0.pop_front();
        check("dut0 ack cycle", cyc, e.cyc);
        check("dut0 ack data", b0.data_o, e.data);
      end
    end else check("dut0 idle data", b0.data_o, 0);
    if (b1.ack_o) begin
      if (q1.size() == 0) check("dut1 spurious ack", 256'(b1.ack_o), 0);
      else begin
        e = q1.pop_front();
        check("dut1 ack cycle", cyc, e.cyc);
        check("dut1 ack data", b1.data_o, e.data);
      end
    end else check("dut1 idle data", b1.data_o, 0);
  end
  // mode: 0 plain, 1 drop enable mid-wait, 2 scramble inputs mid-wait
  task automatic issue(int s, bit wr, logic [31:0] a, logic [255:0] d, logic [255:0] exp, int mode);
    exp_t e;
    bit got = 1'b0;
    e.cyc  = cyc + (just_acked[s] ? 2 : 1) + (s == 1 ? 1 : 10);
    e.data = wr ? '0 : exp;
    if (s == 0) begin
      b0.addr_i = a; b0.data_i = d; b0.write_i = wr; b0.enable_i = 1'b1;
      q0.push_back(e);
    end else begin
      b1.addr_i = a; b1.data_i = d; b1.write_i = wr; b1.enable_i = 1'b1;
      q1.push_back(e);
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 2 && mode == 1) begin
        if (s == 0) b0.enable_i = 1'b0;
        else b1.enable_i = 1'b0;
      end
      if (k == 3 && mode == 2 && s == 0) begin
        b0.addr_i = 32'h20; b0.write_i = 1'b1; b0.data_i = '1;
      end
      got = s == 1 ? b1.ack_o : b0.ack_o;
    end
    check("ack seen", 256'(got), 1);
    just_acked[s] = 1'b1;
  endtask
  task automatic idle(int s, int n);
    if (s == 0) b0.enable_i = 1'b0;
    else b1.enable_i = 1'b0;
    repeat (n) @(negedge clk);
    just_acked[s] = 1'b0;
  endtask
  localparam logic [255:0] LD = {8{32'hDEADBEEF}};
  localparam logic [255:0] L1 = 256'h1111_1111;
  localparam logic [255:0] L2 = 256'h2222_2222;
  localparam logic [255:0] LW = {16{16'hA5C3}};
  localparam logic [255:0] L5 = 256'h5555_5555;
  localparam logic [255:0] L7 = 256'h7777_0007;
  localparam logic [255:0] H1 = 256'hCAFE_F00D;
  localparam logic [255:0] H2 = {4{64'h0123_4567_89AB_CDEF}};
  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    b0.addr_i = '0; b0.data_i = '0; b0.write_i = 1'b0; b0.enable_i = 1'b0;
    b1.addr_i = '0; b1.data_i = '0; b1.write_i = 1'b0; b1.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ack dut0", 256'(b0.ack_o), 0);
    check("reset data dut0", b0.data_o, 0);
    check("reset ack dut1", 256'(b1.ack_o), 0);
    check("reset data dut1", b1.data_o, 0);
    rst0 = 1'b1; rst1 = 1'b1;
    just_acked[0] = 1'b0; just_acked[1] = 1'b0;
    issue(0, 1, 32'h60, LD, 0, 0); idle(0, 3);
    issue(0, 0, 32'h60, 0, LD, 0); idle(0, 1);
    issue(0, 1, 32'h400, 256'h0123_4567, 0, 0);
    issue(0, 0, 32'h400, 0, 256'h0123_4567, 0); idle(0, 1);
    issue(0, 1, 32'h20, L1, 0, 0);
    issue(0, 1, 32'h40, L2, 0, 0);
    issue(0, 0, 32'h40, 0, L2, 2); idle(0, 1);
    issue(0, 0, 32'h20, 0, L1, 0); idle(0, 2);
    issue(0, 1, 32'h401F, LW, 0, 0);
    issue(0, 0, 32'h0, 0, LW, 0); idle(0, 1);
    issue(0, 1, 32'hA0, L5, 0, 0); idle(0, 2);
    b0.addr_i = 32'hA0; b0.data_i = 256'hBAD; b0.write_i = 1'b1; b0.enable_i = 1'b1;
    repeat (4) @(negedge clk);
    rst0 = 1'b0; b0.enable_i = 1'b0;
    @(negedge clk);
    check("mid-reset ack", 256'(b0.ack_o), 0);
    @(negedge clk);
    rst0 = 1'b1; just_acked[0] = 1'b0;
    issue(0, 0, 32'hA0, 0, L5, 0); idle(0, 1);
    issue(0, 1, 32'hE0, L7, 0, 1); idle(0, 1);
    issue(0, 0, 32'hE0, 0, L7, 0); idle(0, 1);
    issue(1, 1, 32'h20, H1, 0, 0);
    issue(1, 0, 32'h20, 0, H1, 0);
    issue(1, 1, 32'h3FE0, H2, 0, 0);
    issue(1, 0, 32'h3FE0, 0, H2, 0);
    issue(1, 0, 32'h20, 0, H1, 0); idle(1, 2);
    repeat (5) @(negedge clk);
    check("dut0 queue drained", 256'(q0.size()), 0);
    check("dut1 queue drained", 256'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
